// File: rtl/mul_pkg.sv
// Shared definitions for the multi-cycle multiply sequencer: ALUControl
// multiply encodings, sequencer state type and an op-validity helper.
package mul_pkg;

  localparam logic [2:0] OP_MUL   = 3'b101;
  localparam logic [2:0] OP_UMULL = 3'b110;
  localparam logic [2:0] OP_SMULL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_WLO  = 2'd2,
    S_WHI  = 2'd3
  } state_t;

  function automatic logic isValidOp(input logic [2:0] opCode);
    return (opCode == OP_MUL) || (opCode == OP_UMULL) || (opCode == OP_SMULL);
  endfunction

endpackage

// File: rtl/mul_shift_add.sv
// Radix-2 shift-add datapath: accumulator, multiplicand shift register,
// multiplier shift register, bit counter and final sign correction.
// Optional macro MUL_EARLY_EXIT_EN ends the iteration once no set
// multiplier bits remain.
module mul_shift_add
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_load,
  input  logic                 i_step,
  input  logic                 i_signed,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic                 o_last,
  output logic [2*WIDTH-1:0]   o_prodNext,
  output logic [2*WIDTH-1:0]   o_product
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_count;
  logic               r_neg;

  logic [WIDTH-1:0]   w_magA;
  logic [WIDTH-1:0]   w_magB;
  logic [2*WIDTH-1:0] w_accNext;

  // Signed operands are reduced to magnitudes; the most negative value maps
  // to 2^(WIDTH-1), which the unsigned WIDTH-bit register holds exactly.
  always_comb begin
    w_magA = (i_signed && i_a[WIDTH-1]) ? (~i_a + 1'b1) : i_a;
    w_magB = (i_signed && i_b[WIDTH-1]) ? (~i_b + 1'b1) : i_b;
  end

  // One multiplier bit per step: add the shifted multiplicand when the bit
  // is set, and apply the sign correction to the value being finalised.
  always_comb begin
    w_accNext  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    o_prodNext = r_neg ? (~w_accNext + 1'b1) : w_accNext;
`ifdef MUL_EARLY_EXIT_EN
    o_last     = (r_mplier[WIDTH-1:1] == '0) || (r_count == LAST_COUNT);
`else
    o_last     = (r_count == LAST_COUNT);
`endif
  end

  // Load operands on accept, then iterate; the last step stores the
  // sign-corrected product so the high half is ready for the second write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
      r_neg    <= 1'b0;
    end else if (i_load) begin
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, w_magA};
      r_mplier <= w_magB;
      r_count  <= '0;
      r_neg    <= i_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
    end else if (i_step) begin
      r_acc    <= o_last ? o_prodNext : w_accNext;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + 1'b1;
    end
  end

  assign o_product = r_acc;

endmodule

// File: rtl/mul_seq.sv
// Multi-cycle multiply sequencer (MUL, UMULL, SMULL) for the multicycle ARM
// core: accepts a request, runs the shift-add datapath and sequences one or
// two register-file writes with N/Z flags on the final write.
// Optional macro MUL_EARLY_EXIT_EN shortens the calculation phase.
module mul_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             wr_en,
  output logic             wr_sel,
  output logic [WIDTH-1:0] wr_data,
  output logic             done,
  output logic [1:0]       flags_nz
);

  state_t             r_state;
  logic [2:0]         r_op;

  logic               w_accept;
  logic               w_step;
  logic               w_last;
  logic [2*WIDTH-1:0] w_prodNext;
  logic [2*WIDTH-1:0] w_product;

  assign w_accept = (r_state == S_IDLE) && start && isValidOp(op);
  assign w_step   = (r_state == S_CALC);

  mul_shift_add #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_accept),
    .i_step     (w_step),
    .i_signed   (op == OP_SMULL),
    .i_a        (a),
    .i_b        (b),
    .o_last     (w_last),
    .o_prodNext (w_prodNext),
    .o_product  (w_product)
  );

  // Sequencer FSM with registered write, done and flag outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      busy     <= 1'b0;
      wr_en    <= 1'b0;
      wr_sel   <= 1'b0;
      wr_data  <= '0;
      done     <= 1'b0;
      flags_nz <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_CALC;
            r_op    <= op;
            busy    <= 1'b1;
          end
        end
        S_CALC: begin
          if (w_last) begin
            r_state <= S_WLO;
            wr_en   <= 1'b1;
            wr_sel  <= 1'b0;
            wr_data <= w_prodNext[WIDTH-1:0];
            if (r_op == OP_MUL) begin
              done     <= 1'b1;
              flags_nz <= {w_prodNext[WIDTH-1], (w_prodNext[WIDTH-1:0] == '0)};
            end
          end
        end
        S_WLO: begin
          if (r_op == OP_MUL) begin
            r_state  <= S_IDLE;
            busy     <= 1'b0;
            wr_en    <= 1'b0;
            wr_data  <= '0;
            done     <= 1'b0;
            flags_nz <= '0;
          end else begin
            r_state  <= S_WHI;
            wr_sel   <= 1'b1;
            wr_data  <= w_product[2*WIDTH-1:WIDTH];
            done     <= 1'b1;
            flags_nz <= {w_product[2*WIDTH-1], (w_product == '0)};
          end
        end
        S_WHI: begin
          r_state  <= S_IDLE;
          busy     <= 1'b0;
          wr_en    <= 1'b0;
          wr_sel   <= 1'b0;
          wr_data  <= '0;
          done     <= 1'b0;
          flags_nz <= '0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
